// File: rtl/tdc_pkg.sv
// Shared constants and helpers for the pipelined TDC thermometer encoder.
package tdc_pkg;

    localparam int unsigned TDC_N_TAPS_DEF = 64;
    localparam int unsigned TDC_BK_LEN_DEF = 4;
    localparam int unsigned TDC_FRAC_W_DEF = 10;

    // Index reported when no edge is present
    localparam int unsigned TDC_IDX_NONE = 0;

    // Width of an edge_t fixed-point value: integer tap index plus fraction
    function automatic int unsigned edge_w(input int unsigned int_w, input int unsigned frac_w);
        return int_w + frac_w;
    endfunction

endpackage

// File: rtl/tdc_prio_enc.sv
// Lowest-set-bit priority encoder: index of the lowest asserted input plus a hit flag.
module tdc_prio_enc
    import tdc_pkg::*;
#(
    parameter int unsigned N     = 61,
    parameter int unsigned IDX_W = 6
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx_c,
    output logic             found_c
);

    // Scan from the top so the lowest set bit is the last one written
    always_comb begin
        idx_c   = IDX_W'(TDC_IDX_NONE);
        found_c = 1'b0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx_c   = IDX_W'(i);
                found_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tdc_encoder_pipe.sv
// Two-stage pipelined TDC encoder: first rising/falling edge with bubble killer,
// held edges across missed captures, half-period and loss-of-lock tracking.
// Optional macro TDC_AVG_EN: half_period becomes a 4-entry running average.
module tdc_encoder_pipe
    import tdc_pkg::*;
#(
    parameter int unsigned N_TAPS   = TDC_N_TAPS_DEF,
    parameter int unsigned BK_LEN   = TDC_BK_LEN_DEF,
    parameter int unsigned FRAC_W   = TDC_FRAC_W_DEF,
    parameter int unsigned INT_W    = $clog2(N_TAPS),
    parameter int unsigned MISS_MAX = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    input  logic [N_TAPS-1:0]                samples,
    input  logic                             inv_dir,
    output logic                             out_valid,
    output logic [INT_W+FRAC_W-1:0]          edge_rise,
    output logic [INT_W+FRAC_W-1:0]          edge_fall,
    output logic                             rise_found,
    output logic                             fall_found,
    output logic [INT_W+FRAC_W-1:0]          half_period,
    output logic [$clog2(MISS_MAX+1)-1:0]    miss_cnt,
    output logic                             lock_err
);

    localparam int unsigned EDGE_W = edge_w(INT_W, FRAC_W);
    localparam int unsigned MISS_W = $clog2(MISS_MAX + 1);
    localparam int unsigned N_POS  = N_TAPS - BK_LEN + 1;

    logic [N_TAPS-1:0] s1_v;
    logic              s1_valid;

    logic [N_POS-1:0]  rise_raw;
    logic [N_POS-1:0]  fall_raw;
    logic [N_POS-1:0]  rise_vec;
    logic [N_POS-1:0]  fall_vec;
    logic [INT_W-1:0]  rise_idx_c;
    logic [INT_W-1:0]  fall_idx_c;
    logic              rise_hit_c;
    logic              fall_hit_c;

    logic [EDGE_W-1:0] rise_nxt_c;
    logic [EDGE_W-1:0] fall_nxt_c;
    logic [EDGE_W-1:0] diff_c;
    logic [EDGE_W-1:0] half_nxt_c;
    logic [MISS_W-1:0] miss_nxt_c;
    logic              complete_c;

    // Stage 1: capture the direction-corrected snapshot with its valid bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v     <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_v <= inv_dir ? ~samples : samples;
            end
        end
    end

    // Bubble-killer windows: BK_LEN-1 quiet taps followed by the new level
    for (genvar gi = 0; gi < int'(N_POS); gi++) begin : g_win
        assign rise_raw[gi] =  s1_v[gi+BK_LEN-1] & ~(|s1_v[gi +: BK_LEN-1]);
        assign fall_raw[gi] = ~s1_v[gi+BK_LEN-1] &  (&s1_v[gi +: BK_LEN-1]);
    end

    // Position 0 is never reported
    assign rise_vec = rise_raw & ~N_POS'(1);
    assign fall_vec = fall_raw & ~N_POS'(1);

    tdc_prio_enc #(.N(N_POS), .IDX_W(INT_W)) u_rise_enc (
        .vec     (rise_vec),
        .idx_c   (rise_idx_c),
        .found_c (rise_hit_c)
    );

    tdc_prio_enc #(.N(N_POS), .IDX_W(INT_W)) u_fall_enc (
        .vec     (fall_vec),
        .idx_c   (fall_idx_c),
        .found_c (fall_hit_c)
    );

    // Next edge values (held when missing), their distance and miss counter
    always_comb begin
        rise_nxt_c = rise_hit_c ? {rise_idx_c, {FRAC_W{1'b0}}} : edge_rise;
        fall_nxt_c = fall_hit_c ? {fall_idx_c, {FRAC_W{1'b0}}} : edge_fall;
        diff_c     = (rise_nxt_c >= fall_nxt_c) ? (rise_nxt_c - fall_nxt_c)
                                                : (fall_nxt_c - rise_nxt_c);
        complete_c = rise_hit_c & fall_hit_c;
        miss_nxt_c = miss_cnt;
        if (complete_c) begin
            miss_nxt_c = '0;
        end else if (miss_cnt != MISS_W'(MISS_MAX)) begin
            miss_nxt_c = miss_cnt + MISS_W'(1);
        end
    end

`ifdef TDC_AVG_EN
    logic [EDGE_W-1:0] hist     [4];
    logic [EDGE_W-1:0] hist_nxt [4];
    logic [EDGE_W+1:0] hist_sum_c;

    // History shifts in the instantaneous difference on complete results only
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            hist_nxt[k] = hist[k];
        end
        if (s1_valid && complete_c) begin
            hist_nxt[0] = diff_c;
            for (int k = 1; k < 4; k++) begin
                hist_nxt[k] = hist[k-1];
            end
        end
        hist_sum_c = (EDGE_W+2)'(hist_nxt[0]) + (EDGE_W+2)'(hist_nxt[1])
                   + (EDGE_W+2)'(hist_nxt[2]) + (EDGE_W+2)'(hist_nxt[3]);
        half_nxt_c = EDGE_W'(hist_sum_c >> 2);
    end

    // History register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                hist[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                hist[k] <= hist_nxt[k];
            end
        end
    end
`else
    assign half_nxt_c = diff_c;
`endif

    // Stage 2: result registers, updated only when a result is produced
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            edge_rise   <= '0;
            edge_fall   <= '0;
            rise_found  <= 1'b0;
            fall_found  <= 1'b0;
            half_period <= '0;
            miss_cnt    <= '0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                edge_rise   <= rise_nxt_c;
                edge_fall   <= fall_nxt_c;
                rise_found  <= rise_hit_c;
                fall_found  <= fall_hit_c;
                half_period <= half_nxt_c;
                miss_cnt    <= miss_nxt_c;
            end
        end
    end

    assign lock_err = (miss_cnt == MISS_W'(MISS_MAX));

endmodule

// File: tb/tb_tdc_encoder_pipe.sv
// Scoreboard bench for tdc_encoder_pipe at default parameters.
module tb_tdc_encoder_pipe;
    import tdc_pkg::*;

    localparam int NT = 64;
    localparam int BK = 4;
    localparam int FW = 10;
    localparam int MM = 8;

    localparam logic [63:0] PAT_BASIC  = 64'h0000_0000_00FF_FF00;
    localparam logic [63:0] PAT_BUBBLE = 64'h0000_0000_00FF_FF04;
    localparam logic [63:0] PAT_LOCK   = 64'hFFFF_FFFF_FF80_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] samples = '0;
    logic        inv_dir = 1'b0;
    logic        out_valid;
    logic [15:0] edge_rise;
    logic [15:0] edge_fall;
    logic        rise_found;
    logic        fall_found;
    logic [15:0] half_period;
    logic [3:0]  miss_cnt;
    logic        lock_err;

    typedef struct packed {
        logic [15:0] rise;
        logic [15:0] fall;
        logic        rf;
        logic        ff;
        logic [15:0] half;
        logic [3:0]  miss;
        logic        lerr;
    } res_t;

    res_t exp_q[$];
    res_t e;
    res_t last_e;
    int   total = 0;
    int   bad = 0;

    logic [15:0] m_rise;
    logic [15:0] m_fall;
    int          m_miss;
`ifdef TDC_AVG_EN
    logic [15:0] m_hist[4];
`endif

    always #5 clk = ~clk;

    tdc_encoder_pipe dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .samples     (samples),
        .inv_dir     (inv_dir),
        .out_valid   (out_valid),
        .edge_rise   (edge_rise),
        .edge_fall   (edge_fall),
        .rise_found  (rise_found),
        .fall_found  (fall_found),
        .half_period (half_period),
        .miss_cnt    (miss_cnt),
        .lock_err    (lock_err)
    );

    function automatic res_t actual();
        return {edge_rise, edge_fall, rise_found, fall_found, half_period, miss_cnt, lock_err};
    endfunction

    // Lowest window position 1..NT-BK showing the requested transition, -1 if none
    function automatic int find_edge(input logic [63:0] v, input logic rising);
        logic ok;
        for (int i = 1; i <= NT - BK; i++) begin
            ok = (v[i+BK-1] == rising);
            for (int j = 0; j < BK - 1; j++) begin
                if (v[i+j] == rising) ok = 1'b0;
            end
            if (ok) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_rise = '0;
        m_fall = '0;
        m_miss = 0;
`ifdef TDC_AVG_EN
        for (int k = 0; k < 4; k++) m_hist[k] = '0;
`endif
        exp_q.delete();
    endtask

    task automatic model_push(input logic [63:0] s, input logic inv);
        logic [63:0] v;
        logic [15:0] d;
        res_t        r;
        int          ri;
        int          fi;
        logic        complete;
        v  = inv ? ~s : s;
        ri = find_edge(v, 1'b1);
        fi = find_edge(v, 1'b0);
        if (ri >= 0) m_rise = 16'(ri) << FW;
        if (fi >= 0) m_fall = 16'(fi) << FW;
        complete = (ri >= 0) && (fi >= 0);
        d = (m_rise >= m_fall) ? (m_rise - m_fall) : (m_fall - m_rise);
        if (complete) m_miss = 0;
        else if (m_miss < MM) m_miss = m_miss + 1;
`ifdef TDC_AVG_EN
        if (complete) begin
            for (int k = 3; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = d;
        end
        r.half = 16'((int'(m_hist[0]) + int'(m_hist[1]) + int'(m_hist[2]) + int'(m_hist[3])) >> 2);
`else
        r.half = d;
`endif
        r.rise = m_rise;
        r.fall = m_fall;
        r.rf   = (ri >= 0);
        r.ff   = (fi >= 0);
        r.miss = 4'(m_miss);
        r.lerr = (m_miss == MM);
        exp_q.push_back(r);
    endtask

    // One-cycle capture; afterwards inputs are scrambled to prove they are sampled once
    task automatic pulse(input logic [63:0] s, input logic inv);
        @(posedge clk); #1;
        samples  = s;
        inv_dir  = inv;
        in_valid = 1'b1;
        model_push(s, inv);
        @(posedge clk); #1;
        in_valid = 1'b0;
        inv_dir  = ~inv;
        samples  = {$urandom, $urandom};
    endtask

    task automatic wait_result(output logic got);
        got = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({out_valid, actual()} !== '0) begin
            bad++;
            $display("FAIL reset_state got=%h want=0", {out_valid, actual()});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        @(posedge clk); #1;
        samples  = PAT_BASIC;
        inv_dir  = 1'b0;
        in_valid = 1'b1;
        model_push(PAT_BASIC, 1'b0);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL latency_c0 got=%b want=0", out_valid); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        inv_dir  = 1'b1;
        samples  = {$urandom, $urandom};
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL latency_c1 got=%b want=0", out_valid); end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL latency_c2 got=%b want=1", out_valid); end
        total++;
        e = exp_q.pop_front();
        if (actual() !== e) begin bad++; $display("FAIL sb_basic got=%h want=%h", actual(), e); end
        total++;
        if (edge_rise !== 16'h1400 || edge_fall !== 16'h5400 || !rise_found || !fall_found || miss_cnt !== 4'd0) begin
            bad++;
            $display("FAIL basic_edges got rise=%h fall=%h rf=%b ff=%b miss=%0d want rise=1400 fall=5400 rf=1 ff=1 miss=0",
                     edge_rise, edge_fall, rise_found, fall_found, miss_cnt);
        end
`ifndef TDC_AVG_EN
        total++;
        if (half_period !== 16'h4000) begin bad++; $display("FAIL basic_half got=%h want=4000", half_period); end
`endif
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL valid_pulse got=%b want=0", out_valid); end
    endtask

    task automatic test_inv();
        logic got;
        pulse(PAT_BASIC, 1'b1);
        wait_result(got);
        total++;
        if (!got) begin bad++; $display("FAIL inv_timeout got=0 want=1"); end
        else begin
            e = exp_q.pop_front();
            if (actual() !== e) begin bad++; $display("FAIL sb_inv got=%h want=%h", actual(), e); end
        end
        total++;
        if (edge_rise !== 16'h5400 || edge_fall !== 16'h1400) begin
            bad++;
            $display("FAIL inv_edges got rise=%h fall=%h want rise=5400 fall=1400", edge_rise, edge_fall);
        end
`ifndef TDC_AVG_EN
        total++;
        if (half_period !== 16'h4000) begin bad++; $display("FAIL inv_half got=%h want=4000", half_period); end
`endif
    endtask

    task automatic test_bubble();
        logic got;
        pulse(PAT_BUBBLE, 1'b0);
        wait_result(got);
        total++;
        if (!got) begin bad++; $display("FAIL bubble_timeout got=0 want=1"); end
        else begin
            e = exp_q.pop_front();
            if (actual() !== e) begin bad++; $display("FAIL sb_bubble got=%h want=%h", actual(), e); end
        end
        total++;
        if (edge_rise !== 16'h1400 || edge_fall !== 16'h5400) begin
            bad++;
            $display("FAIL bubble_edges got rise=%h fall=%h want rise=1400 fall=5400", edge_rise, edge_fall);
        end
    endtask

    task automatic test_lock();
        logic got;
        for (int k = 0; k < 9; k++) begin
            pulse(PAT_LOCK, 1'b0);
            wait_result(got);
            total++;
            if (!got) begin bad++; $display("FAIL lock_timeout k=%0d got=0 want=1", k); end
            else begin
                e = exp_q.pop_front();
                last_e = e;
                if (actual() !== e) begin bad++; $display("FAIL sb_lock k=%0d got=%h want=%h", k, actual(), e); end
            end
            if (k == 0) begin
                total++;
                if (edge_rise !== 16'h5000 || fall_found !== 1'b0 || edge_fall !== 16'h5400 || miss_cnt !== 4'd1) begin
                    bad++;
                    $display("FAIL lock_first got rise=%h ff=%b fall=%h miss=%0d want rise=5000 ff=0 fall=5400 miss=1",
                             edge_rise, fall_found, edge_fall, miss_cnt);
                end
            end
            if (k == 7 || k == 8) begin
                total++;
                if (miss_cnt !== 4'd8 || lock_err !== 1'b1) begin
                    bad++;
                    $display("FAIL lock_sat k=%0d got miss=%0d lerr=%b want miss=8 lerr=1", k, miss_cnt, lock_err);
                end
            end
        end
        repeat (3) @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || actual() !== last_e) begin
            bad++;
            $display("FAIL idle_hold got v=%b res=%h want v=0 res=%h", out_valid, actual(), last_e);
        end
        pulse(PAT_BASIC, 1'b0);
        wait_result(got);
        total++;
        if (!got) begin bad++; $display("FAIL relock_timeout got=0 want=1"); end
        else begin
            e = exp_q.pop_front();
            if (actual() !== e) begin bad++; $display("FAIL sb_relock got=%h want=%h", actual(), e); end
        end
        total++;
        if (miss_cnt !== 4'd0 || lock_err !== 1'b0) begin
            bad++;
            $display("FAIL relock got miss=%0d lerr=%b want miss=0 lerr=0", miss_cnt, lock_err);
        end
    endtask

    task automatic test_back_to_back();
        int          cnt;
        int          first;
        int          last;
        int          a;
        int          b;
        logic [63:0] s;
        logic        inv;
        cnt   = 0;
        first = -1;
        last  = -1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (k < 5) begin
                a   = $urandom_range(1, 20);
                b   = a + $urandom_range(4, 30);
                s   = ((64'd1 << b) - 64'd1) & ~((64'd1 << a) - 64'd1);
                inv = 1'($urandom_range(0, 1));
                samples  = s;
                inv_dir  = inv;
                in_valid = 1'b1;
                model_push(s, inv);
            end else begin
                in_valid = 1'b0;
                samples  = {$urandom, $urandom};
                inv_dir  = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            if (out_valid === 1'b1) begin
                cnt++;
                if (first < 0) first = k;
                last = k;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_extra k=%0d got=out_valid want=none", k);
                end else begin
                    e = exp_q.pop_front();
                    if (actual() !== e) begin bad++; $display("FAIL sb_b2b k=%0d got=%h want=%h", k, actual(), e); end
                end
            end
        end
        total++;
        if (cnt != 5 || (last - first) != 4) begin
            bad++;
            $display("FAIL b2b_stream got cnt=%0d span=%0d want cnt=5 span=4", cnt, last - first);
        end
    endtask

    task automatic test_reset_flight();
        logic got;
        int   stray;
        stray = 0;
        @(posedge clk); #1;
        samples  = PAT_BASIC;
        inv_dir  = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        samples  = PAT_BUBBLE;
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        model_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stray++;
        end
        total++;
        if (stray != 0 || actual() !== '0) begin
            bad++;
            $display("FAIL reset_flight got stray=%0d res=%h want stray=0 res=0", stray, actual());
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        pulse(PAT_BASIC, 1'b0);
        wait_result(got);
        total++;
        if (!got) begin bad++; $display("FAIL post_reset_timeout got=0 want=1"); end
        else begin
            e = exp_q.pop_front();
            if (actual() !== e) begin bad++; $display("FAIL sb_post_reset got=%h want=%h", actual(), e); end
        end
    endtask

`ifdef TDC_AVG_EN
    task automatic test_avg();
        logic        got;
        logic [15:0] want;
        test_reset();
        for (int k = 0; k < 4; k++) begin
            pulse(PAT_BASIC, 1'b0);
            wait_result(got);
            want = 16'((k + 1) * 16'h1000);
            total++;
            if (!got) begin bad++; $display("FAIL avg_timeout k=%0d got=0 want=1", k); end
            else begin
                e = exp_q.pop_front();
                if (actual() !== e) begin bad++; $display("FAIL sb_avg k=%0d got=%h want=%h", k, actual(), e); end
            end
            total++;
            if (half_period !== want) begin
                bad++;
                $display("FAIL avg_half k=%0d got=%h want=%h", k, half_period, want);
            end
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_inv();
        test_bubble();
        test_lock();
        test_back_to_back();
        test_reset_flight();
`ifdef TDC_AVG_EN
        test_avg();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
